// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural PC and picks sequential advance, hold,
// branch redirect (deferred across an I-cache miss) or halt each cycle.
module fetch_pc_sequencer #(
    parameter int               PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000,
    parameter int               CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             imem_busy_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    input  logic             halt_dec_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [PC_W-1:0]  pc_inc_o,
    output logic             imem_req_o,
    output logic             if_valid_o,
    output logic             flush_ifid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] miss_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MISS       = 2'd1,
        ST_MISS_REDIR = 2'd2,
        ST_HALT       = 2'd3
    } state_e;

    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              halted_q;
    logic [PC_W-1:0]   pc_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign pc_inc_s = pc_q + PC_STEP;

    // Next-state, next-PC and pending-redirect selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    if (imem_busy_i) begin
                        pend_pc_d = redirect_pc_i;
                        state_d   = ST_MISS_REDIR;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (imem_busy_i) begin
                    state_d = ST_MISS;
                end else if (halt_dec_i) begin
                    state_d = ST_HALT;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            ST_MISS: begin
                if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                    state_d   = ST_MISS_REDIR;
                end else if (!imem_busy_i) begin
                    state_d = ST_RUN;
                    if (stall_i) begin
                        pc_d = pc_q;
                    end else begin
                        pc_d = pc_inc_s;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_MISS_REDIR: begin
                // The deferred target is taken even under stall: the filled word is wrong-path.
                if (!imem_busy_i) begin
                    pc_d    = pend_pc_q;
                    state_d = ST_RUN;
                end else if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                end else begin
                    pend_pc_d = pend_pc_q;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Saturating count of cycles the I-cache reports a miss while not halted
    always_comb begin
        if (imem_busy_i && (state_q != ST_HALT)) begin
            miss_d = sat_inc(miss_q);
        end else begin
            miss_d = miss_q;
        end
    end

    // State, PC, pending target, counter and halt flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= {PC_W{1'b0}};
            miss_q    <= {CNT_W{1'b0}};
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            miss_q    <= miss_d;
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // Fetch handshake outputs; all forced low while reset is held
    always_comb begin
        imem_req_o   = 1'b0;
        if_valid_o   = 1'b0;
        flush_ifid_o = 1'b0;
        if (rst_ni) begin
            imem_req_o   = (state_q != ST_HALT);
            if_valid_o   = (state_q == ST_RUN) && !imem_busy_i && !redirect_i && !halt_dec_i;
            flush_ifid_o = (redirect_i && (state_q != ST_HALT)) ||
                           ((state_q == ST_MISS_REDIR) && !imem_busy_i);
        end else begin
            imem_req_o   = 1'b0;
        end
    end

    assign pc_o          = pc_q;
    assign pc_inc_o      = pc_inc_s;
    assign halted_o      = halted_q;
    assign miss_cycles_o = miss_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: a vector table for the main sequence
// plus hand-written halt, wrap and asynchronous-reset sequences.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, busy, redir, halt;
    logic [15:0] rpc;
    logic [15:0] pc, pc_inc, miss;
    logic        req, ifv, fl, hlt;

    int n_checks = 0;
    int n_err    = 0;

    fetch_pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stall_i      (stall),
        .imem_busy_i  (busy),
        .redirect_i   (redir),
        .redirect_pc_i(rpc),
        .halt_dec_i   (halt),
        .pc_o         (pc),
        .pc_inc_o     (pc_inc),
        .imem_req_o   (req),
        .if_valid_o   (ifv),
        .flush_ifid_o (fl),
        .halted_o     (hlt),
        .miss_cycles_o(miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, busy, redir;
        logic [15:0] rpc;
        logic        halt;
        logic [15:0] pc;
        logic        ifv, fl, req, hlt;
        logic [15:0] miss;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic s, input logic b, input logic r, input logic [15:0] t,
                                input logic h, input logic [15:0] p, input logic v, input logic f,
                                input logic q, input logic hh, input logic [15:0] m);
        vec_t x;
        x.stall = s; x.busy = b; x.redir = r; x.rpc = t; x.halt = h;
        x.pc = p; x.ifv = v; x.fl = f; x.req = q; x.hlt = hh; x.miss = m;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic r, input logic [15:0] t, input logic h);
        stall = s; busy = b; redir = r; rpc = t; halt = h;
    endtask

    initial begin
        //                  stl bsy rdr rpc       hlt  pc        ifv  fl   req  hlt  miss
        tbl[0]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0000,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0002,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0004,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0006,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[4]  = mk(1'b0,1'b0,1'b1,16'h0010,1'b0, 16'h0008,1'b0,1'b1,1'b1,1'b0,16'd0);
        tbl[5]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h0010,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[6]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h0010,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[7]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0010,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0012,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[9]  = mk(1'b0,1'b0,1'b1,16'h0020,1'b0, 16'h0014,1'b0,1'b1,1'b1,1'b0,16'd0);
        tbl[10] = mk(1'b0,1'b0,1'b1,16'h0100,1'b0, 16'h0020,1'b0,1'b1,1'b1,1'b0,16'd0);
        tbl[11] = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0100,1'b1,1'b0,1'b1,1'b0,16'd0);
        tbl[12] = mk(1'b0,1'b0,1'b1,16'h0030,1'b0, 16'h0102,1'b0,1'b1,1'b1,1'b0,16'd0);
        tbl[13] = mk(1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h0030,1'b0,1'b0,1'b1,1'b0,16'd0);
        tbl[14] = mk(1'b0,1'b1,1'b1,16'h0180,1'b0, 16'h0030,1'b0,1'b1,1'b1,1'b0,16'd1);
        tbl[15] = mk(1'b0,1'b1,1'b1,16'h0200,1'b0, 16'h0030,1'b0,1'b1,1'b1,1'b0,16'd2);
        tbl[16] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h0030,1'b0,1'b1,1'b1,1'b0,16'd3);
        tbl[17] = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0200,1'b1,1'b0,1'b1,1'b0,16'd3);
        tbl[18] = mk(1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h0202,1'b0,1'b0,1'b1,1'b0,16'd3);
        tbl[19] = mk(1'b0,1'b1,1'b0,16'h0000,1'b1, 16'h0202,1'b0,1'b0,1'b1,1'b0,16'd4);
        tbl[20] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h0202,1'b0,1'b0,1'b1,1'b0,16'd5);
        tbl[21] = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0202,1'b1,1'b0,1'b1,1'b0,16'd5);
        tbl[22] = mk(1'b0,1'b0,1'b1,16'h0040,1'b0, 16'h0204,1'b0,1'b1,1'b1,1'b0,16'd5);
        tbl[23] = mk(1'b0,1'b0,1'b1,16'h0300,1'b1, 16'h0040,1'b0,1'b1,1'b1,1'b0,16'd5);
        tbl[24] = mk(1'b0,1'b0,1'b1,16'h0040,1'b0, 16'h0300,1'b0,1'b1,1'b1,1'b0,16'd5);
        tbl[25] = mk(1'b0,1'b0,1'b0,16'h0000,1'b1, 16'h0040,1'b0,1'b0,1'b1,1'b0,16'd5);
        tbl[26] = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h0040,1'b0,1'b0,1'b0,1'b1,16'd5);
        tbl[27] = mk(1'b1,1'b1,1'b1,16'h0500,1'b1, 16'h0040,1'b0,1'b0,1'b0,1'b1,16'd5);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        #1;
        check("reset_req", {31'd0, req}, 32'd0);
        check("reset_flush", {31'd0, fl}, 32'd0);
        check("reset_ifv", {31'd0, ifv}, 32'd0);
        check("reset_pc", {16'd0, pc}, 32'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Main vector table: drive at negedge, compare 1 time unit later, then clock
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].stall, tbl[i].busy, tbl[i].redir, tbl[i].rpc, tbl[i].halt);
            #1;
            check($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, tbl[i].pc});
            check($sformatf("v%0d_pc_inc", i), {16'd0, pc_inc}, {16'd0, tbl[i].pc + 16'd2});
            check($sformatf("v%0d_if_valid", i), {31'd0, ifv}, {31'd0, tbl[i].ifv});
            check($sformatf("v%0d_flush", i), {31'd0, fl}, {31'd0, tbl[i].fl});
            check($sformatf("v%0d_imem_req", i), {31'd0, req}, {31'd0, tbl[i].req});
            check($sformatf("v%0d_halted", i), {31'd0, hlt}, {31'd0, tbl[i].hlt});
            check($sformatf("v%0d_miss", i), {16'd0, miss}, {16'd0, tbl[i].miss});
            @(negedge clk);
        end

        // Halt is sticky: pc frozen for 10 cycles regardless of inputs
        for (int k = 0; k < 10; k++) begin
            drive(k[0], k[1], 1'b1, 16'h0A00 + 16'(k), k[2]);
            #1;
            check($sformatf("halt%0d_pc", k), {16'd0, pc}, 32'h0040);
            check($sformatf("halt%0d_halted", k), {31'd0, hlt}, 32'd1);
            check($sformatf("halt%0d_flush", k), {31'd0, fl}, 32'd0);
            check($sformatf("halt%0d_miss", k), {16'd0, miss}, 32'd5);
            @(negedge clk);
        end

        // Asynchronous reset out of HALT, mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_halt_pc", {16'd0, pc}, 32'h0000);
        check("rst_halt_halted", {31'd0, hlt}, 32'd0);
        check("rst_halt_req", {31'd0, req}, 32'd0);
        check("rst_halt_flush", {31'd0, fl}, 32'd0);
        check("rst_halt_miss", {16'd0, miss}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect to FFFE, then free-run across the wrap
        drive(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        #1;
        check("wrap_first_pc", {16'd0, pc}, 32'h0000);
        check("wrap_first_req", {31'd0, req}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check("wrap_pc_fffe", {16'd0, pc}, 32'hFFFE);
        check("wrap_pc_inc", {16'd0, pc_inc}, 32'h0000);
        check("wrap_ifv", {31'd0, ifv}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        #1;
        check("wrap_pc_0000", {16'd0, pc}, 32'h0000);
        @(negedge clk);

        // Enter a miss at 1234, then drop reset asynchronously
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        #1;
        check("miss_entry_pc", {16'd0, pc}, 32'h1234);
        @(negedge clk);
        #1;
        check("miss_hold_pc", {16'd0, pc}, 32'h1234);
        check("miss_hold_cnt", {16'd0, miss}, 32'd1);
        check("miss_hold_ifv", {31'd0, ifv}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_miss_pc", {16'd0, pc}, 32'h0000);
        check("rst_miss_cnt", {16'd0, miss}, 32'd0);
        check("rst_miss_req", {31'd0, req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check("post_rst_pc", {16'd0, pc}, 32'h0000);
        check("post_rst_ifv", {31'd0, ifv}, 32'd1);
        check("post_rst_req", {31'd0, req}, 32'd1);
        @(negedge clk);
        #1;
        check("post_rst_adv", {16'd0, pc}, 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch each cycle.
- Selects between sequential advance, hold (decode hazard stall or instruction-cache miss), branch redirect from the branch-resolution logic, and halt.
- Defers a redirect that resolves during an outstanding I-cache miss until the miss completes, so the cache is never re-addressed mid-fill.
- Sits between the branch-resolution unit, the hazard unit, the I-cache and the IF/ID pipeline register.

Parameters:
- PC_W, 16, PC and address width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating miss-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard stall from decode; hold PC.
- imem_busy  input  1  I-cache miss in progress; the word at pc is not yet valid.
- redirect  input  1  taken branch or flush from branch resolution.
- redirect_pc  input  PC_W  branch target; valid when redirect=1.
- halt_dec  input  1  HLT instruction decoded.
- pc  output  PC_W  current fetch address to the I-cache.
- pc_inc  output  PC_W  pc+2, modulo 2^PC_W; feeds the branch adder base.
- imem_req  output  1  fetch enable to the I-cache.
- if_valid  output  1  fetched word may be written into IF/ID as a valid instruction.
- flush_ifid  output  1  invalidate the IF/ID contents this cycle.
- halted  output  1  core is halted.
- miss_cycles  output  CNT_W  count of cycles spent with imem_busy=1; saturates.

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=RUN, pend_pc=0, miss_cycles=0, halted=0. While reset is asserted, imem_req=0, if_valid=0 and flush_ifid=0.
- Reset mid-miss or mid-halt aborts the current state immediately. The first fetch after reset release is RESET_PC.
- States: RUN, MISS, MISS_REDIR, HALT. Internal register pend_pc (PC_W bits).
- Input priority, highest first: redirect, imem_busy, halt_dec, stall.
- RUN:
  - redirect=1, imem_busy=0: pc<=redirect_pc; stay in RUN.
  - redirect=1, imem_busy=1: pend_pc<=redirect_pc; pc held; go to MISS_REDIR.
  - imem_busy=1, no redirect: pc held; go to MISS.
  - halt_dec=1, no redirect, imem_busy=0: pc held; go to HALT. halt_dec is ignored when redirect=1 in the same cycle (wrong-path HLT).
  - stall=1, none of the above: pc held.
  - Otherwise: pc<=pc+2.
- MISS:
  - redirect=1: pend_pc<=redirect_pc; go to MISS_REDIR. Checked before imem_busy.
  - Else imem_busy=0: go to RUN. pc<=pc+2 unless stall=1, in which case pc is held.
  - Else: pc held.
  - halt_dec is ignored in MISS.
- MISS_REDIR:
  - imem_busy=0: pc<=pend_pc; go to RUN. This applies even when stall=1.
  - A further redirect while imem_busy=1: pend_pc<=redirect_pc (latest redirect wins).
- HALT: pc is frozen; all inputs are ignored; only rst_n exits.
- imem_req = 1 in RUN, MISS and MISS_REDIR; 0 in HALT.
- if_valid = (state==RUN) & !imem_busy & !redirect & !halt_dec. This is combinational. The stall gating of the IF/ID write is done outside this block.
- flush_ifid is combinational:
  - 1 when redirect=1 in any state except HALT.
  - 1 in the cycle MISS_REDIR exits to RUN, since the completed word is wrong-path.
- halted = (state==HALT); registered.
- miss_cycles increments each cycle imem_busy=1 with state!=HALT. It holds at 2^CNT_W-1.
- pc_inc is combinational and wraps: 16'hFFFE+2=16'h0000. Sequential advance wraps the same way.
- Latency: a redirect in cycle N gives pc=redirect_pc in N+1 when not missing. If missing, the new pc appears the cycle after imem_busy falls.

Test Plan:
- Reset release, no stalls for 4 cycles -> pc 0000, 0002, 0004, 0006; if_valid=1; pc_inc=pc+2.
- At pc=0010 assert stall for 2 cycles -> pc holds 0010 for 2 cycles, then 0012; flush_ifid=0 throughout.
- At pc=0020 assert redirect with redirect_pc=0100, imem_busy=0 -> flush_ifid=1 and if_valid=0 that cycle; next pc=0100.
- At pc=0030 raise imem_busy for 3 cycles, then redirect with redirect_pc=0200 in busy cycle 2 -> pc stays 0030 while busy; flush_ifid=1 on the redirect cycle and on the exit cycle; pc=0200 the cycle after imem_busy falls; miss_cycles=3.
- halt_dec at pc=0040 with no redirect -> halted=1 next cycle; imem_req=0; pc frozen at 0040 for 10 cycles. Same stimulus with redirect=1 in the same cycle -> no halt, pc=redirect_pc.
- Force pc to FFFE via redirect, then free-run -> next pc=0000. Drop rst_n asynchronously during a miss -> pc=0000 immediately; state RUN after release.
